// File: rtl/score_pkg.sv
// Shared definitions for the score display: FSM encoding, segment patterns,
// default parameter values and the double-dabble step helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package score_pkg;

  localparam int BW_DEF             = 7;
  localparam int REFRESH_CYCLES_DEF = 1000;
  localparam int BLANK_LZ_DEF       = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Segments a..g on bits 0..6, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One double-dabble step on a two-digit accumulator: correct any nibble
  // >= 5 by adding 3, then shift left taking the next binary bit in.
  // Overflow past the tens digit only happens for inputs > 99, whose
  // result is discarded anyway.
  function automatic logic [7:0] dd_step(input logic [7:0] acc, input logic bit_in);
    logic [7:0] adj;
    adj = acc;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], bit_in};
  endfunction

endpackage

// File: rtl/score_display_seg7_dec.sv
// BCD digit to 7-segment decoder; non-decimal codes decode to blank.
// Latency: combinational. Backpressure: none.
// Ports: i_bcd (4-bit digit) -> o_seg (segments a..g on bits 0..6).
module seg7_dec
  import score_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Converts a binary score to two BCD digits (serial double-dabble) and
// drives a multiplexed two-digit 7-segment display.
// Latency: bcd_o/err_o update BW+1 edges after the sampling edge.
// Backpressure: none; input changes while busy_o is high are picked up
// by the idle compare once the current conversion finishes.
// Ports: clk_i, rst_n_i (async, active-low), counter_val_i (binary score),
//        bcd_o (tens/ones), err_o (score > 99), busy_o, seg_o, dig_sel_o.
module score_display
  import score_pkg::*;
#(
  parameter int BW             = BW_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int BLANK_LZ       = BLANK_LZ_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [BW-1:0] counter_val_i,
  output logic [7:0]    bcd_o,
  output logic          err_o,
  output logic          busy_o,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o
);

  localparam int CW = $clog2(BW + 1);
  localparam int RW = $clog2(REFRESH_CYCLES);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [BW-1:0]   r_val;      // value under conversion
  logic [BW-1:0]   r_sh;       // binary bits still to be shifted in
  logic [7:0]      r_acc;      // BCD accumulator
  logic [CW-1:0]   r_cnt;      // shift steps completed
  logic [BW-1:0]   r_last;     // last converted value
  logic [7:0]      r_bcd;
  logic            r_err;
  logic [RW-1:0]   r_ref;
  logic [1:0]      r_dig_sel;

  logic            w_diff;
  logic            w_start;
  logic            w_step;
  logic            w_update;
  logic            w_busy;
  logic            w_over;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg_dec;

  assign w_diff = (counter_val_i != r_last);
  assign w_over = (32'(r_val) > 32'd99);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_diff) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == CW'(BW - 1)) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs / datapath strobes
  always_comb begin
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_update = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      ST_IDLE:   w_start = w_diff;
      ST_SHIFT:  begin w_step = 1'b1; w_busy = 1'b1; end
      ST_UPDATE: begin w_update = 1'b1; w_busy = 1'b1; end
      default:   ;
    endcase
  end

  // Conversion datapath. Results only land in r_bcd/r_err/r_last on the
  // UPDATE edge, so a reset mid-conversion leaves no partial result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_val  <= '0;
      r_sh   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      r_bcd  <= 8'h00;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_val <= counter_val_i;
        r_sh  <= counter_val_i;
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (w_step) begin
        r_acc <= dd_step(r_acc, r_sh[BW-1]);
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_update) begin
        r_last <= r_val;
        if (w_over) begin
          r_err <= 1'b1;           // keep the last good score on bcd_o
        end else begin
          r_err <= 1'b0;
          r_bcd <= r_acc;
        end
      end
    end
  end

  // Free-running digit refresh: each digit stays selected REFRESH_CYCLES.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ref     <= '0;
      r_dig_sel <= 2'b01;
    end else if (r_ref == RW'(REFRESH_CYCLES - 1)) begin
      r_ref     <= '0;
      r_dig_sel <= ~r_dig_sel;
    end else begin
      r_ref     <= r_ref + 1'b1;
    end
  end

  assign w_digit = r_dig_sel[1] ? r_bcd[7:4] : r_bcd[3:0];

  seg7_dec u_seg7_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  // Segment output is built from registered state only.
  always_comb begin
    seg_o = w_seg_dec;
    if (r_err)
      seg_o = SEG_DASH;
    else if ((BLANK_LZ != 0) && r_dig_sel[1] && (r_bcd[7:4] == 4'd0))
      seg_o = SEG_BLANK;
  end

  assign bcd_o     = r_bcd;
  assign err_o     = r_err;
  assign busy_o    = w_busy;
  assign dig_sel_o = r_dig_sel;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a scoreboard: stimulus pushes the
// expected {bcd, err} per conversion, a monitor pops on each busy_o fall.
module tb_score_display;

  logic       clk;
  logic       rst_n;
  logic [6:0] cval;
  logic [7:0] bcd;
  logic       err;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  typedef struct packed {
    logic [7:0] bcd;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  score_display #(
    .BW             (7),
    .REFRESH_CYCLES (4),
    .BLANK_LZ       (1)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .counter_val_i (cval),
    .bcd_o         (bcd),
    .err_o         (err),
    .busy_o        (busy),
    .seg_o         (seg),
    .dig_sel_o     (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [6:0] v, input logic [7:0] exp_bcd, input logic exp_err);
    exp_t e;
    tick();
    cval = v;
    e.bcd = exp_bcd;
    e.err = exp_err;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!busy && i < 5) begin @(negedge clk); i++; end
    chk({name, "_start"}, {31'd0, busy}, 32'd1);
    i = 0;
    while (busy && i < 20) begin @(negedge clk); i++; end
    chk({name, "_end"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_digits(input string name, input logic [6:0] ones, input logic [6:0] tens);
    bit got_o;
    bit got_t;
    got_o = 0;
    got_t = 0;
    for (int i = 0; i < 12 && !(got_o && got_t); i++) begin
      @(negedge clk);
      if (dig_sel == 2'b01 && !got_o) begin
        chk({name, "_ones"}, {25'd0, seg}, {25'd0, ones});
        got_o = 1;
      end else if (dig_sel == 2'b10 && !got_t) begin
        chk({name, "_tens"}, {25'd0, seg}, {25'd0, tens});
        got_t = 1;
      end
    end
    chk({name, "_both_seen"}, {31'd0, got_o & got_t}, 32'd1);
  endtask

  // Monitor: a busy_o fall outside reset marks a completed conversion.
  initial begin
    logic       prev_busy;
    int         len;
    logic [7:0] bcd_start;
    logic       stable;
    exp_t       e;
    prev_busy = 1'b0;
    len       = 0;
    bcd_start = 8'h00;
    stable    = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        len       = 0;
        continue;
      end
      if (busy) begin
        if (!prev_busy) begin
          len       = 0;
          bcd_start = bcd;
          stable    = 1'b1;
        end
        len++;
        if (bcd !== bcd_start) stable = 1'b0;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got conversion with bcd=%0h err=%0b, required none", bcd, err);
        end else begin
          e = sb_q.pop_front();
          chk("sb_bcd", {24'd0, bcd}, {24'd0, e.bcd});
          chk("sb_err", {31'd0, err}, {31'd0, e.err});
          chk("sb_busy_len", len, 32'd8);
          chk("sb_bcd_stable_while_busy", {31'd0, stable}, 32'd1);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [1:0] exp_sel;
    bit         found;
    exp_t       e;
    rst_n = 1'b0;
    cval  = 7'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bcd", {24'd0, bcd}, 32'h00);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dig_sel", {30'd0, dig_sel}, 32'd1);
    chk("rst_seg", {25'd0, seg}, 32'h3F);

    // Release; input stays 0 so no conversion, refresh runs from 0.
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_sel = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
      chk("refresh_sel", {30'd0, dig_sel}, {30'd0, exp_sel});
      chk("refresh_seg", {25'd0, seg}, (exp_sel == 2'b01) ? 32'h3F : 32'h00);
    end

    // 42
    apply(7'd42, 8'h42, 1'b0);
    wait_done("conv42");
    check_digits("seg42", 7'b1011011, 7'b1100110);

    // 99 then 100
    apply(7'd99, 8'h99, 1'b0);
    wait_done("conv99");
    check_digits("seg99", 7'b1101111, 7'b1101111);
    apply(7'd100, 8'h99, 1'b1);
    wait_done("conv100");
    check_digits("seg100", 7'b1000000, 7'b1000000);

    // 10, changed to 11 during the third SHIFT cycle
    apply(7'd10, 8'h10, 1'b0);
    tick();
    tick();
    tick();
    cval  = 7'd11;
    e.bcd = 8'h11;
    e.err = 1'b0;
    sb_q.push_back(e);
    wait_done("conv10");
    wait_done("conv11");
    check_digits("seg11", 7'b0000110, 7'b0000110);

    // Reset during SHIFT while converting 57
    apply(7'd57, 8'h57, 1'b0);
    void'(sb_q.pop_back());   // this conversion is aborted
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bcd", {24'd0, bcd}, 32'h00);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    e.bcd = 8'h57;
    e.err = 1'b0;
    sb_q.push_back(e);
    found = 0;
    for (int i = 0; i < 9 && !found; i++) begin
      tick();
      if (bcd == 8'h57) found = 1;
    end
    chk("rst_mid_recover57", {31'd0, found}, 32'd1);
    repeat (3) tick();
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
